// File: rtl/mux2_pkg.sv
// Shared constants and select encoding for the two-input mux slice.
// The select-switch counter is built only with MUX2_SWITCH_CNT_EN.
package mux2_pkg;

    localparam int WIDTH_DEF = 1;
    localparam int CNT_W_DEF = 16;

    typedef enum logic {
        SEL_A = 1'b0,
        SEL_B = 1'b1
    } sel_e;

endpackage

// File: rtl/mux2_switch_cnt.sv
// Saturating up-counter with enable and async active-low clear.
// It counts select changes and stops at all-ones rather than wrapping.
module mux2_switch_cnt
    import mux2_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mux2_ver.sv
// Two-input mux with combinational Y, a registered copy Y_q and select-change
// monitoring; sw_cnt exists only when MUX2_SWITCH_CNT_EN is defined.
module mux2_ver
    import mux2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Select,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_q,
    output logic             sel_chg
`ifdef MUX2_SWITCH_CNT_EN
    ,
    output logic [CNT_W-1:0] sw_cnt
`endif
);

    sel_e sel;
    logic sel_q;
    logic sel_chg_q;
    logic sel_chg_d;

    if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
        $error("mux2_ver: WIDTH and CNT_W must be at least 1");
    end

    // Data path never touches a register, so Y stays valid through reset.
    assign sel = sel_e'(Select);
    assign Y   = (sel == SEL_B) ? B_in : A_in;

    assign sel_chg_d = (Select != sel_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y_q       <= '0;
            sel_q     <= SEL_A;
            sel_chg_q <= 1'b0;
        end else begin
            Y_q       <= Y;
            sel_q     <= Select;
            sel_chg_q <= sel_chg_d;
        end
    end

    assign sel_chg = sel_chg_q;

`ifdef MUX2_SWITCH_CNT_EN
    mux2_switch_cnt #(
        .CNT_W(CNT_W)
    ) u_switch_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en_i (sel_chg_d),
        .cnt_o(sw_cnt)
    );
`endif

endmodule

// File: tb/tb_mux2_ver.sv
// Directed self-checking bench for mux2_ver: a WIDTH=1/CNT_W=16 instance and a
// WIDTH=8/CNT_W=4 instance share clock and reset.
module tb_mux2_ver;

    logic       clk;
    logic       rst_n;
    logic       sel1;
    logic       a1;
    logic       b1;
    logic       y1;
    logic       yq1;
    logic       chg1;
    logic       sel8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [7:0] y8;
    logic [7:0] yq8;
    logic       chg8;
`ifdef MUX2_SWITCH_CNT_EN
    logic [15:0] cnt1;
    logic [3:0]  cnt8;
`endif

    int total = 0;
    int bad   = 0;

    mux2_ver #(.WIDTH(1), .CNT_W(16)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .Select (sel1),
        .A_in   (a1),
        .B_in   (b1),
        .Y      (y1),
        .Y_q    (yq1),
        .sel_chg(chg1)
`ifdef MUX2_SWITCH_CNT_EN
        ,
        .sw_cnt (cnt1)
`endif
    );

    mux2_ver #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .Select (sel8),
        .A_in   (a8),
        .B_in   (b8),
        .Y      (y8),
        .Y_q    (yq8),
        .sel_chg(chg8)
`ifdef MUX2_SWITCH_CNT_EN
        ,
        .sw_cnt (cnt8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] tt;
        logic [2:0] v;
        int         exp_sat;

        // Expected Y indexed by {Select, A_in, B_in}.
        tt    = 8'b1010_1100;
        rst_n = 1'b0;
        sel1  = 1'b0;
        a1    = 1'b0;
        b1    = 1'b0;
        sel8  = 1'b0;
        a8    = 8'hA5;
        b8    = 8'h3C;
        #1;
        check("rst_yq", {31'd0, yq1}, 32'd0);
        check("rst_chg", {31'd0, chg1}, 32'd0);
        check("rst_yq8", {24'd0, yq8}, 32'd0);
`ifdef MUX2_SWITCH_CNT_EN
        check("rst_cnt", {16'd0, cnt1}, 32'd0);
        check("rst_cnt8", {28'd0, cnt8}, 32'd0);
`endif

        check("w8_sel0", {24'd0, y8}, 32'h0000_00A5);
        sel8 = 1'b1;
        #1;
        check("w8_sel1", {24'd0, y8}, 32'h0000_003C);
        sel8 = 1'b0;

        // Truth table runs while reset is held: Y must not depend on it.
        for (int rep = 0; rep < 12; rep++) begin
            for (int i = 0; i < 8; i++) begin
                v = i[2:0];
                {sel1, a1, b1} = v;
                #5;
                check("truth", {31'd0, y1}, {31'd0, tt[v]});
            end
        end
        check("rst_hold_yq", {31'd0, yq1}, 32'd0);

        // Registered path.
        @(negedge clk);
        sel1  = 1'b0;
        a1    = 1'b1;
        b1    = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("yq_a", {31'd0, yq1}, 32'd1);
        check("chg_idle", {31'd0, chg1}, 32'd0);
        sel1 = 1'b1;
        #1;
        check("y_immediate", {31'd0, y1}, 32'd0);
        check("yq_before_edge", {31'd0, yq1}, 32'd1);
        @(negedge clk);
        check("yq_after_edge", {31'd0, yq1}, 32'd0);
        check("chg_first", {31'd0, chg1}, 32'd1);
`ifdef MUX2_SWITCH_CNT_EN
        check("cnt_first", {16'd0, cnt1}, 32'd1);
`endif
        @(negedge clk);
        check("chg_one_cycle", {31'd0, chg1}, 32'd0);

        // Data activity with Select held.
        b1 = 1'b1;
        @(negedge clk);
        check("data_yq1", {31'd0, yq1}, 32'd1);
        check("data_chg1", {31'd0, chg1}, 32'd0);
        b1 = 1'b0;
        @(negedge clk);
        check("data_yq0", {31'd0, yq1}, 32'd0);
        check("data_chg0", {31'd0, chg1}, 32'd0);
        b1 = 1'b1;
        @(negedge clk);
`ifdef MUX2_SWITCH_CNT_EN
        check("data_cnt", {16'd0, cnt1}, 32'd1);
`endif

        // Mid-operation async reset with a pulse in flight.
        sel1 = 1'b0;
        @(negedge clk);
        check("pre_rst_chg", {31'd0, chg1}, 32'd1);
        check("pre_rst_yq", {31'd0, yq1}, 32'd1);
`ifdef MUX2_SWITCH_CNT_EN
        check("pre_rst_cnt", {16'd0, cnt1}, 32'd2);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("async_yq", {31'd0, yq1}, 32'd0);
        check("async_chg", {31'd0, chg1}, 32'd0);
        check("async_y", {31'd0, y1}, 32'd1);
`ifdef MUX2_SWITCH_CNT_EN
        check("async_cnt", {16'd0, cnt1}, 32'd0);
`endif
        a1 = 1'b0;
        #1;
        check("rst_y_follow", {31'd0, y1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_sel0_chg", {31'd0, chg1}, 32'd0);

        // Five consecutive select toggles.
        for (int k = 1; k <= 5; k++) begin
            sel1 = ~sel1;
            @(negedge clk);
            check("toggle_chg", {31'd0, chg1}, 32'd1);
`ifdef MUX2_SWITCH_CNT_EN
            check("toggle_cnt", {16'd0, cnt1}, k);
`endif
        end
        @(negedge clk);
        check("toggle_end_chg", {31'd0, chg1}, 32'd0);
`ifdef MUX2_SWITCH_CNT_EN
        check("toggle_end_cnt", {16'd0, cnt1}, 32'd5);
`endif

        // Glitch between edges is invisible.
        sel1 = 1'b0;
        #2;
        sel1 = 1'b1;
        @(negedge clk);
        check("glitch_chg", {31'd0, chg1}, 32'd0);
`ifdef MUX2_SWITCH_CNT_EN
        check("glitch_cnt", {16'd0, cnt1}, 32'd5);
`endif

        // Release with Select=1 fires a change since sel_q resets low.
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_sel1_chg", {31'd0, chg1}, 32'd1);
`ifdef MUX2_SWITCH_CNT_EN
        check("rel_sel1_cnt", {16'd0, cnt1}, 32'd1);
`endif

        // Saturation on the CNT_W=4 instance.
        for (int k = 1; k <= 20; k++) begin
            sel8 = ~sel8;
            @(negedge clk);
            check("sat_chg8", {31'd0, chg8}, 32'd1);
            exp_sat = (k > 15) ? 15 : k;
`ifdef MUX2_SWITCH_CNT_EN
            check("sat_cnt8", {28'd0, cnt8}, exp_sat);
`endif
        end
        @(negedge clk);
        check("sat_end_chg8", {31'd0, chg8}, 32'd0);
        check("w8_yq", {24'd0, yq8}, 32'h0000_00A5);
`ifdef MUX2_SWITCH_CNT_EN
        check("sat_end_cnt8", {28'd0, cnt8}, 32'd15);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
